instr_prefetch_unit: RTL and testbench

INSTR_PREFETCH_UNIT -- requirements
Module: instr_prefetch_unit

---
 rtl/instr_prefetch_unit.sv | 112 +++++++++++
 tb/tb_instr_prefetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: small load-able instruction memory, a RUN/HALTED
// fetch FSM and a circular prefetch queue presented to the IF/ID stage.
module instr_prefetch_unit #(
    parameter int          IMEM_WORDS = 32,
    parameter int          QDEPTH     = 4,
    parameter logic [7:0]  HALT_CODE  = 8'hFF,
    localparam int         PCW        = $clog2(IMEM_WORDS),
    localparam int         CW         = $clog2(QDEPTH + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_en,
    input  logic [PCW-1:0] load_addr,
    input  logic [7:0]     load_data,
    input  logic           redirect,
    input  logic [PCW-1:0] redirect_pc,
    input  logic           instr_ready,
    output logic           instr_valid,
    output logic [7:0]     instr_out,
    output logic [PCW-1:0] instr_pc,
    output logic           halted,
    output logic [CW-1:0]  q_count
);

    localparam int PTRW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [7:0]     imem    [IMEM_WORDS];
    logic [7:0]     q_instr [QDEPTH];
    logic [PCW-1:0] q_pc    [QDEPTH];

    logic [0:0]     state;
    logic [PCW-1:0] fetch_pc;
    logic [PTRW-1:0] rd_ptr;
    logic [PTRW-1:0] wr_ptr;
    logic [CW-1:0]  count;
    logic [7:0]     hold_instr;
    logic [PCW-1:0] hold_pc;

    logic [7:0]     fetch_word;
    logic           full;
    logic           do_enq;
    logic           do_deq;
    logic [PTRW-1:0] rd_next;
    logic [PTRW-1:0] wr_next;
    logic [PCW-1:0] pc_next;

    assign fetch_word = imem[fetch_pc];
    assign full       = (count == CW'(QDEPTH));
    assign do_enq     = (state == ST_RUN) && !full && !load_en;
    assign do_deq     = instr_valid && instr_ready;
    assign rd_next    = (rd_ptr == PTRW'(QDEPTH - 1)) ? '0 : rd_ptr + PTRW'(1);
    assign wr_next    = (wr_ptr == PTRW'(QDEPTH - 1)) ? '0 : wr_ptr + PTRW'(1);
    assign pc_next    = (fetch_pc == PCW'(IMEM_WORDS - 1)) ? '0 : fetch_pc + PCW'(1);

    // Memory is deliberately left out of reset so a program can be loaded while reset is held.
    always_ff @(posedge clk) begin
        if (load_en)
            imem[load_addr] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (!reset && !redirect && do_enq) begin
            q_instr[wr_ptr] <= fetch_word;
            q_pc[wr_ptr]    <= fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_RUN;
            fetch_pc   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            hold_instr <= 8'h00;
            hold_pc    <= '0;
        end else if (redirect) begin
            state    <= ST_RUN;
            fetch_pc <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr   <= wr_next;
                fetch_pc <= pc_next;
                if (fetch_word == HALT_CODE)
                    state <= ST_HALTED;
            end
            // Remember the departing head so an empty queue keeps showing it.
            if (do_deq) begin
                rd_ptr     <= rd_next;
                hold_instr <= q_instr[rd_ptr];
                hold_pc    <= q_pc[rd_ptr];
            end
            if (do_enq && !do_deq)
                count <= count + CW'(1);
            else if (!do_enq && do_deq)
                count <= count - CW'(1);
        end
    end

    assign instr_valid = (count != '0);
    assign instr_out   = instr_valid ? q_instr[rd_ptr] : hold_instr;
    assign instr_pc    = instr_valid ? q_pc[rd_ptr]    : hold_pc;
    assign halted      = (state == ST_HALTED);
    assign q_count     = count;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Scoreboard bench for instr_prefetch_unit: directed programs, expected
// deliveries queued by the stimulus and checked by an independent monitor.
module tb_instr_prefetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_en;
    logic [4:0] load_addr;
    logic [7:0] load_data;
    logic       redirect;
    logic [4:0] redirect_pc;
    logic       instr_ready;
    logic       instr_valid;
    logic [7:0] instr_out;
    logic [4:0] instr_pc;
    logic       halted;
    logic [2:0] q_count;

    typedef struct packed {
        logic [7:0] instr;
        logic [4:0] pc;
    } entry_t;

    entry_t     exp_q[$];
    logic [7:0] mem_model [32];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    instr_prefetch_unit #(
        .IMEM_WORDS(32),
        .QDEPTH    (4),
        .HALT_CODE (8'hFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_ready(instr_ready),
        .instr_valid(instr_valid),
        .instr_out  (instr_out),
        .instr_pc   (instr_pc),
        .halted     (halted),
        .q_count    (q_count)
    );

    // Monitor: every accepted head must match the oldest expected delivery.
    always @(negedge clk) begin
        if (!reset && !redirect && instr_valid && instr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_delivery: got %02h@%0d required none", instr_out, instr_pc);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                if ({instr_out, instr_pc} !== e) begin
                    errors++;
                    $display("[TB] FAIL delivery: got %02h@%0d required %02h@%0d",
                             instr_out, instr_pc, e.instr, e.pc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic redir, input logic [4:0] rpc);
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = rpc;
    endtask

    task automatic loadWord(input logic [4:0] addr, input logic [7:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        mem_model[addr] = data;
        tick();
        load_en = 1'b0;
    endtask

    task automatic pushExp(input logic [4:0] pc);
        exp_q.push_back({mem_model[pc], pc});
    endtask

    // Waits (bounded) for all expected deliveries, then stops accepting.
    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_timeout: got %0d pending required 0 pending", name, exp_q.size());
            exp_q.delete();
        end
        instr_ready = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        load_en     = 1'b0;
        load_addr   = '0;
        load_data   = '0;
        applyStimulus(1'b0, 1'b0, 5'd0);
        tick();

        for (int i = 0; i < 32; i++)
            loadWord(5'(i), 8'h80 + 8'(i));

        // Short program ending in a halt word, loaded while reset is held.
        loadWord(5'd0, 8'h12);
        loadWord(5'd1, 8'h34);
        loadWord(5'd2, 8'h56);
        loadWord(5'd3, 8'hFF);
        checkOutput("reset_valid",  32'(instr_valid), 32'd0);
        checkOutput("reset_qcount", 32'(q_count),     32'd0);
        checkOutput("reset_out",    32'(instr_out),   32'h00);
        checkOutput("reset_pc",     32'(instr_pc),    32'd0);
        checkOutput("reset_halted", 32'(halted),      32'd0);
        for (int i = 0; i < 4; i++)
            pushExp(5'(i));
        instr_ready = 1'b1;
        reset       = 1'b0;
        drain("halt_prog", 20);
        checkOutput("halt_halted", 32'(halted),      32'd1);
        checkOutput("halt_valid",  32'(instr_valid), 32'd0);
        tick();
        tick();
        checkOutput("halt_no_fetch", 32'(q_count), 32'd0);

        // Backpressure: queue fills, then drains in order.
        reset = 1'b1;
        for (int i = 0; i < 8; i++)
            loadWord(5'(i), 8'h80 + 8'(i));
        reset = 1'b0;
        repeat (6) tick();
        checkOutput("full_qcount", 32'(q_count),     32'd4);
        checkOutput("full_valid",  32'(instr_valid), 32'd1);
        checkOutput("full_out",    32'(instr_out),   32'(mem_model[0]));
        checkOutput("full_pc",     32'(instr_pc),    32'd0);
        for (int i = 0; i < 8; i++)
            pushExp(5'(i));
        instr_ready = 1'b1;
        drain("backpressure", 40);

        // Redirect flushes a full queue and overrides the handshake.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (6) tick();
        applyStimulus(1'b1, 1'b1, 5'd10);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0);
        checkOutput("redir_qcount", 32'(q_count),     32'd0);
        checkOutput("redir_valid",  32'(instr_valid), 32'd0);
        tick();
        checkOutput("redir_first_valid", 32'(instr_valid), 32'd1);
        checkOutput("redir_first_out",   32'(instr_out),   32'(mem_model[10]));
        checkOutput("redir_first_pc",    32'(instr_pc),    32'd10);
        pushExp(5'd10);
        pushExp(5'd11);
        instr_ready = 1'b1;
        drain("redirect", 20);

        // Fetch address wraps from 31 back to 0.
        for (int p = 30; p < 34; p++)
            pushExp(5'(p % 32));
        applyStimulus(1'b1, 1'b1, 5'd30);
        tick();
        redirect = 1'b0;
        drain("wrap", 20);

        // Load while running stalls fetch; then run into a halt and redirect out.
        repeat (6) tick();
        loadWord(5'd20, 8'hFF);
        checkOutput("load_stall_qcount", 32'(q_count), 32'd4);
        pushExp(5'd18);
        pushExp(5'd19);
        pushExp(5'd20);
        applyStimulus(1'b1, 1'b1, 5'd18);
        tick();
        redirect = 1'b0;
        drain("halt_mid", 20);
        checkOutput("halt_mid_halted", 32'(halted), 32'd1);
        tick();
        tick();
        checkOutput("halt_mid_qcount", 32'(q_count), 32'd0);
        pushExp(5'd5);
        pushExp(5'd6);
        applyStimulus(1'b1, 1'b1, 5'd5);
        tick();
        redirect = 1'b0;
        checkOutput("unhalt_halted", 32'(halted), 32'd0);
        drain("unhalt", 20);

        // Reset mid-operation discards the queue and restarts at address 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        checkOutput("midrst_pre_qcount", 32'(q_count),     32'd3);
        checkOutput("midrst_pre_valid",  32'(instr_valid), 32'd1);
        reset = 1'b1;
        tick();
        checkOutput("midrst_valid",  32'(instr_valid), 32'd0);
        checkOutput("midrst_qcount", 32'(q_count),     32'd0);
        checkOutput("midrst_out",    32'(instr_out),   32'h00);
        checkOutput("midrst_pc",     32'(instr_pc),    32'd0);
        checkOutput("midrst_halted", 32'(halted),      32'd0);
        reset = 1'b0;
        pushExp(5'd0);
        instr_ready = 1'b1;
        drain("midrst", 20);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
